// File: rtl/mem_access_stage.sv
// mem_access_stage: memory-access stage behind the 64-bit ALU.
// Decodes D/DS-form loads and stores, runs one req/ack bus transaction per
// memory instruction and produces a formatted writeback with a one-cycle
// completion pulse. Non-memory opcodes pass the ALU result straight through.
//
// Handshake rules:
//   upstream : an instruction transfers on a rising edge where in_valid and
//              in_ready are both 1; in_ready is 1 only in IDLE.
//   bus      : mem_req rises after acceptance and stays high with stable
//              addr/we/be/wdata until the edge that samples mem_ack=1; the
//              request drops right after that edge. mem_ack is ignored
//              whenever no request is outstanding.
//   writeback: out_valid is a single-cycle pulse with no backpressure.
module mem_access_stage #(
    parameter int ADDR_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        in_opcode,
    input  logic [1:0]        in_xods,
    input  logic [63:0]       in_alu_result,
    input  logic [63:0]       in_store_data,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_ra,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-4:0] mem_addr,
    output logic [7:0]        mem_be,
    output logic [63:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [63:0]       mem_rdata,
    output logic              out_valid,
    output logic              out_wb_en,
    output logic [4:0]        out_rd,
    output logic [63:0]       out_data,
    output logic              out_exc
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUS  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Access size codes: log2 of the byte count.
    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    // ---------------- decode ----------------
    logic       dec_load;
    logic       dec_store;
    logic       dec_stwu;
    logic       dec_sign;
    logic       dec_illegal;
    logic [1:0] dec_sz;

    // Classify the opcode / DS extended opcode into load, store or pass-through.
    always_comb begin
        dec_load    = 1'b0;
        dec_store   = 1'b0;
        dec_stwu    = 1'b0;
        dec_sign    = 1'b0;
        dec_illegal = 1'b0;
        dec_sz      = SZ_B;
        case (in_opcode)
            6'd34: begin dec_load = 1'b1; dec_sz = SZ_B; end
            6'd40: begin dec_load = 1'b1; dec_sz = SZ_H; end
            6'd42: begin dec_load = 1'b1; dec_sz = SZ_H; dec_sign = 1'b1; end
            6'd32: begin dec_load = 1'b1; dec_sz = SZ_W; end
            6'd58: begin
                if (in_xods == 2'd0) begin
                    dec_load = 1'b1;
                    dec_sz   = SZ_D;
                end else if (in_xods == 2'd2) begin
                    dec_load = 1'b1;
                    dec_sz   = SZ_W;
                    dec_sign = 1'b1;
                end else begin
                    dec_illegal = 1'b1;
                end
            end
            6'd38: begin dec_store = 1'b1; dec_sz = SZ_B; end
            6'd44: begin dec_store = 1'b1; dec_sz = SZ_H; end
            6'd36: begin dec_store = 1'b1; dec_sz = SZ_W; end
            6'd37: begin dec_store = 1'b1; dec_sz = SZ_W; dec_stwu = 1'b1; end
            6'd62: begin
                if (in_xods == 2'd0) begin
                    dec_store = 1'b1;
                    dec_sz    = SZ_D;
                end else begin
                    dec_illegal = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // ---------------- lane placement ----------------
    logic [2:0]  ea_off;
    logic        misaligned;
    logic [3:0]  nbytes;
    logic [3:0]  lane_gap;
    logic [5:0]  lane_shift;
    logic [7:0]  lane_be;
    logic [63:0] size_mask;
    logic [63:0] lane_wdata;

    assign ea_off = in_alu_result[2:0];

    // Alignment check and big-endian lane position for the decoded access.
    // Byte offset k sits at bits [63-8k:56-8k], so an access of n bytes at
    // offset k is right-aligned after shifting by 8*(8-n-k).
    always_comb begin
        misaligned = 1'b0;
        case (dec_sz)
            SZ_H:    misaligned = ea_off[0];
            SZ_W:    misaligned = (ea_off[1:0] != 2'b00);
            SZ_D:    misaligned = (ea_off != 3'b000);
            default: misaligned = 1'b0;
        endcase
        nbytes     = 4'd1 << dec_sz;
        lane_gap   = 4'd8 - nbytes - {1'b0, ea_off};
        lane_shift = {lane_gap[2:0], 3'b000};
        case (dec_sz)
            SZ_B:    begin lane_be = 8'h01; size_mask = 64'h0000_0000_0000_00FF; end
            SZ_H:    begin lane_be = 8'h03; size_mask = 64'h0000_0000_0000_FFFF; end
            SZ_W:    begin lane_be = 8'h0F; size_mask = 64'h0000_0000_FFFF_FFFF; end
            default: begin lane_be = 8'hFF; size_mask = 64'hFFFF_FFFF_FFFF_FFFF; end
        endcase
        lane_be    = lane_be << ea_off;
        lane_wdata = (in_store_data & size_mask) << lane_shift;
    end

    // ---------------- state ----------------
    logic [1:0]        state_q,      state_d;
    logic              mem_req_q,    mem_req_d;
    logic              mem_we_q,     mem_we_d;
    logic [ADDR_W-4:0] mem_addr_q,   mem_addr_d;
    logic [7:0]        mem_be_q,     mem_be_d;
    logic [63:0]       mem_wdata_q,  mem_wdata_d;
    logic              is_load_q,    is_load_d;
    logic [1:0]        ld_sz_q,      ld_sz_d;
    logic              ld_sign_q,    ld_sign_d;
    logic [5:0]        ld_shift_q,   ld_shift_d;
    logic              pend_wb_q,    pend_wb_d;
    logic [4:0]        pend_rd_q,    pend_rd_d;
    logic [63:0]       pend_data_q,  pend_data_d;
    logic              out_valid_q,  out_valid_d;
    logic              out_wb_en_q,  out_wb_en_d;
    logic [4:0]        out_rd_q,     out_rd_d;
    logic [63:0]       out_data_q,   out_data_d;
    logic              out_exc_q,    out_exc_d;

    logic [63:0] ld_raw;
    logic [63:0] ld_result;

    // Right-justify the addressed lanes of the returned doubleword and extend.
    always_comb begin
        ld_raw = mem_rdata >> ld_shift_q;
        case (ld_sz_q)
            SZ_B:    ld_result = {56'd0, ld_raw[7:0]};
            SZ_H:    ld_result = {{48{ld_sign_q & ld_raw[15]}}, ld_raw[15:0]};
            SZ_W:    ld_result = {{32{ld_sign_q & ld_raw[31]}}, ld_raw[31:0]};
            default: ld_result = ld_raw;
        endcase
    end

    // Next-state logic for the IDLE -> (BUS) -> DONE sequence.
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        is_load_d   = is_load_q;
        ld_sz_d     = ld_sz_q;
        ld_sign_d   = ld_sign_q;
        ld_shift_d  = ld_shift_q;
        pend_wb_d   = pend_wb_q;
        pend_rd_d   = pend_rd_q;
        pend_data_d = pend_data_q;
        out_valid_d = 1'b0;
        out_wb_en_d = out_wb_en_q;
        out_rd_d    = out_rd_q;
        out_data_d  = out_data_q;
        out_exc_d   = out_exc_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    if ((dec_load || dec_store) && !misaligned) begin
                        // Memory op: freeze the bus transaction and the writeback plan.
                        state_d     = ST_BUS;
                        mem_req_d   = 1'b1;
                        mem_we_d    = dec_store;
                        mem_addr_d  = in_alu_result[ADDR_W-1:3];
                        mem_be_d    = lane_be;
                        mem_wdata_d = dec_store ? lane_wdata : 64'd0;
                        is_load_d   = dec_load;
                        ld_sz_d     = dec_sz;
                        ld_sign_d   = dec_sign;
                        ld_shift_d  = lane_shift;
                        pend_wb_d   = dec_load | dec_stwu;
                        pend_rd_d   = dec_stwu ? in_ra : in_rd;
                        pend_data_d = in_alu_result;
                    end else begin
                        // Pass-through, misaligned access or illegal DS form.
                        state_d     = ST_DONE;
                        out_valid_d = 1'b1;
                        out_exc_d   = dec_illegal | dec_load | dec_store;
                        out_wb_en_d = ~(dec_illegal | dec_load | dec_store);
                        out_rd_d    = in_rd;
                        out_data_d  = in_alu_result;
                    end
                end
            end
            ST_BUS: begin
                if (mem_ack) begin
                    state_d     = ST_DONE;
                    mem_req_d   = 1'b0;
                    out_valid_d = 1'b1;
                    out_exc_d   = 1'b0;
                    out_wb_en_d = pend_wb_q;
                    out_rd_d    = pend_rd_q;
                    out_data_d  = is_load_q ? ld_result : pend_data_q;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d   = ST_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= 8'd0;
            mem_wdata_q <= 64'd0;
            is_load_q   <= 1'b0;
            ld_sz_q     <= 2'd0;
            ld_sign_q   <= 1'b0;
            ld_shift_q  <= 6'd0;
            pend_wb_q   <= 1'b0;
            pend_rd_q   <= 5'd0;
            pend_data_q <= 64'd0;
            out_valid_q <= 1'b0;
            out_wb_en_q <= 1'b0;
            out_rd_q    <= 5'd0;
            out_data_q  <= 64'd0;
            out_exc_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            is_load_q   <= is_load_d;
            ld_sz_q     <= ld_sz_d;
            ld_sign_q   <= ld_sign_d;
            ld_shift_q  <= ld_shift_d;
            pend_wb_q   <= pend_wb_d;
            pend_rd_q   <= pend_rd_d;
            pend_data_q <= pend_data_d;
            out_valid_q <= out_valid_d;
            out_wb_en_q <= out_wb_en_d;
            out_rd_q    <= out_rd_d;
            out_data_q  <= out_data_d;
            out_exc_q   <= out_exc_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_be    = mem_be_q;
    assign mem_wdata = mem_wdata_q;
    assign out_valid = out_valid_q;
    assign out_wb_en = out_wb_en_q;
    assign out_rd    = out_rd_q;
    assign out_data  = out_data_q;
    assign out_exc   = out_exc_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: a vector table of single instructions
// with hand-computed bus and writeback results, plus hand-written sequences
// for reset, back-to-back issue, stray acks and reset during a bus transfer.
module tb_mem_access_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  in_opcode;
    logic [1:0]  in_xods;
    logic [63:0] in_alu_result;
    logic [63:0] in_store_data;
    logic [4:0]  in_rd;
    logic [4:0]  in_ra;
    logic        mem_req;
    logic        mem_we;
    logic [60:0] mem_addr;
    logic [7:0]  mem_be;
    logic [63:0] mem_wdata;
    logic        mem_ack;
    logic [63:0] mem_rdata;
    logic        out_valid;
    logic        out_wb_en;
    logic [4:0]  out_rd;
    logic [63:0] out_data;
    logic        out_exc;

    int checks;
    int errors;

    mem_access_stage #(.ADDR_W(64)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_xods(in_xods),
        .in_alu_result(in_alu_result), .in_store_data(in_store_data),
        .in_rd(in_rd), .in_ra(in_ra),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_wb_en(out_wb_en), .out_rd(out_rd),
        .out_data(out_data), .out_exc(out_exc)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  op;
        logic [1:0]  xods;
        logic [63:0] alu;
        logic [63:0] sdata;
        logic [4:0]  rd;
        logic [4:0]  ra;
        int          wait_n;
        logic [63:0] rdata;
        logic        req;
        logic        we;
        logic [7:0]  be;
        logic [63:0] wdata;
        logic        wb;
        logic [4:0]  ord;
        logic [63:0] odata;
        logic        exc;
    } vec_t;

    vec_t vecs[19];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Driver: present one instruction, answer the bus, check the completion.
    task automatic run_vec(input int idx, input vec_t v);
        chk($sformatf("v%0d_ready", idx), {63'd0, in_ready}, 64'd1);
        in_valid      = 1'b1;
        in_opcode     = v.op;
        in_xods       = v.xods;
        in_alu_result = v.alu;
        in_store_data = v.sdata;
        in_rd         = v.rd;
        in_ra         = v.ra;
        @(negedge clk);
        in_valid = 1'b0;
        if (v.req) begin
            chk($sformatf("v%0d_req", idx), {63'd0, mem_req}, 64'd1);
            chk($sformatf("v%0d_we", idx), {63'd0, mem_we}, {63'd0, v.we});
            chk($sformatf("v%0d_addr", idx), {3'd0, mem_addr}, v.alu >> 3);
            chk($sformatf("v%0d_be", idx), {56'd0, mem_be}, {56'd0, v.be});
            if (v.we) chk($sformatf("v%0d_wdata", idx), mem_wdata, v.wdata);
            chk($sformatf("v%0d_busy", idx), {63'd0, in_ready}, 64'd0);
            for (int i = 0; i < v.wait_n; i++) begin
                chk($sformatf("v%0d_noval%0d", idx, i), {63'd0, out_valid}, 64'd0);
                @(negedge clk);
                chk($sformatf("v%0d_hold%0d", idx, i), {63'd0, mem_req}, 64'd1);
                chk($sformatf("v%0d_holdbe%0d", idx, i), {56'd0, mem_be}, {56'd0, v.be});
            end
            mem_ack   = 1'b1;
            mem_rdata = v.rdata;
            @(negedge clk);
            mem_ack   = 1'b0;
            mem_rdata = {$urandom, $urandom};
            chk($sformatf("v%0d_req_drop", idx), {63'd0, mem_req}, 64'd0);
        end else begin
            chk($sformatf("v%0d_noreq", idx), {63'd0, mem_req}, 64'd0);
        end
        chk($sformatf("v%0d_valid", idx), {63'd0, out_valid}, 64'd1);
        chk($sformatf("v%0d_exc", idx), {63'd0, out_exc}, {63'd0, v.exc});
        chk($sformatf("v%0d_wb", idx), {63'd0, out_wb_en}, {63'd0, v.wb});
        if (v.wb) begin
            chk($sformatf("v%0d_rd", idx), {59'd0, out_rd}, {59'd0, v.ord});
            chk($sformatf("v%0d_data", idx), out_data, v.odata);
        end
        @(negedge clk);
        chk($sformatf("v%0d_pulse", idx), {63'd0, out_valid}, 64'd0);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_opcode = 6'd0;
        in_xods   = 2'd0;
        in_alu_result = 64'd0;
        in_store_data = 64'd0;
        in_rd     = 5'd0;
        in_ra     = 5'd0;
        mem_ack   = 1'b0;
        mem_rdata = 64'd0;

        //          op     xods  alu                     sdata                   rd     ra     wt rdata                   req  we   be     wdata                   wb   ord    odata                   exc
        vecs[0]  = '{6'd31, 2'd0, 64'h0000_0000_0000_00FF, 64'd0,                 5'd3,  5'd0,  0, 64'd0,                 1'b0,1'b0,8'h00, 64'd0,                 1'b1,5'd3,  64'h0000_0000_0000_00FF,1'b0};
        vecs[1]  = '{6'd42, 2'd0, 64'h0000_0000_0000_1002, 64'd0,                 5'd5,  5'd0,  2, 64'h0000_8001_0000_0000,1'b1,1'b0,8'h0C, 64'd0,                 1'b1,5'd5,  64'hFFFF_FFFF_FFFF_8001,1'b0};
        vecs[2]  = '{6'd38, 2'd0, 64'h0000_0000_0000_2005, 64'hDEAD_BEEF_CAFE_00AB,5'd6,  5'd0,  0, 64'd0,                 1'b1,1'b1,8'h20, 64'h0000_0000_00AB_0000,1'b0,5'd0,  64'd0,                 1'b0};
        vecs[3]  = '{6'd37, 2'd0, 64'h0000_0000_0000_3004, 64'hFFFF_FFFF_1234_5678,5'd9,  5'd7,  1, 64'd0,                 1'b1,1'b1,8'hF0, 64'h0000_0000_1234_5678,1'b1,5'd7,  64'h0000_0000_0000_3004,1'b0};
        vecs[4]  = '{6'd32, 2'd0, 64'h0000_0000_0000_4002, 64'd0,                 5'd4,  5'd0,  0, 64'd0,                 1'b0,1'b0,8'h00, 64'd0,                 1'b0,5'd0,  64'd0,                 1'b1};
        vecs[5]  = '{6'd58, 2'd1, 64'h0000_0000_0000_5000, 64'd0,                 5'd4,  5'd0,  0, 64'd0,                 1'b0,1'b0,8'h00, 64'd0,                 1'b0,5'd0,  64'd0,                 1'b1};
        vecs[6]  = '{6'd34, 2'd0, 64'h0000_0000_0000_6003, 64'd0,                 5'd10, 5'd0,  0, 64'h0011_2233_4455_6677,1'b1,1'b0,8'h08, 64'd0,                 1'b1,5'd10, 64'h0000_0000_0000_0033,1'b0};
        vecs[7]  = '{6'd40, 2'd0, 64'h0000_0000_0000_6006, 64'd0,                 5'd11, 5'd0,  1, 64'h0011_2233_4455_F677,1'b1,1'b0,8'hC0, 64'd0,                 1'b1,5'd11, 64'h0000_0000_0000_F677,1'b0};
        vecs[8]  = '{6'd32, 2'd0, 64'h0000_0000_0000_7000, 64'd0,                 5'd12, 5'd0,  0, 64'h8765_4321_0000_0000,1'b1,1'b0,8'h0F, 64'd0,                 1'b1,5'd12, 64'h0000_0000_8765_4321,1'b0};
        vecs[9]  = '{6'd58, 2'd2, 64'h0000_0000_0000_7004, 64'd0,                 5'd13, 5'd0,  0, 64'h0000_0000_8765_4321,1'b1,1'b0,8'hF0, 64'd0,                 1'b1,5'd13, 64'hFFFF_FFFF_8765_4321,1'b0};
        vecs[10] = '{6'd58, 2'd0, 64'h1234_5678_0000_8008, 64'd0,                 5'd14, 5'd0,  3, 64'h0123_4567_89AB_CDEF,1'b1,1'b0,8'hFF, 64'd0,                 1'b1,5'd14, 64'h0123_4567_89AB_CDEF,1'b0};
        vecs[11] = '{6'd62, 2'd0, 64'h0000_0000_0000_9000, 64'h0123_4567_89AB_CDEF,5'd15, 5'd0,  0, 64'd0,                 1'b1,1'b1,8'hFF, 64'h0123_4567_89AB_CDEF,1'b0,5'd0,  64'd0,                 1'b0};
        vecs[12] = '{6'd44, 2'd0, 64'h0000_0000_0000_A002, 64'h1111_2222_3333_BEEF,5'd16, 5'd0,  0, 64'd0,                 1'b1,1'b1,8'h0C, 64'h0000_BEEF_0000_0000,1'b0,5'd0,  64'd0,                 1'b0};
        vecs[13] = '{6'd58, 2'd0, 64'h0000_0000_0000_8004, 64'd0,                 5'd17, 5'd0,  0, 64'd0,                 1'b0,1'b0,8'h00, 64'd0,                 1'b0,5'd0,  64'd0,                 1'b1};
        vecs[14] = '{6'd42, 2'd0, 64'h0000_0000_0000_1000, 64'd0,                 5'd18, 5'd0,  0, 64'h7FFF_0000_0000_0000,1'b1,1'b0,8'h03, 64'd0,                 1'b1,5'd18, 64'h0000_0000_0000_7FFF,1'b0};
        vecs[15] = '{6'd62, 2'd1, 64'h0000_0000_0000_9000, 64'd0,                 5'd19, 5'd0,  0, 64'd0,                 1'b0,1'b0,8'h00, 64'd0,                 1'b0,5'd0,  64'd0,                 1'b1};
        vecs[16] = '{6'd36, 2'd0, 64'h0000_0000_0000_B000, 64'hAAAA_BBBB_CCCC_DDDD,5'd20, 5'd0,  0, 64'd0,                 1'b1,1'b1,8'h0F, 64'hCCCC_DDDD_0000_0000,1'b0,5'd0,  64'd0,                 1'b0};
        vecs[17] = '{6'd40, 2'd0, 64'h0000_0000_0000_6001, 64'd0,                 5'd21, 5'd0,  0, 64'd0,                 1'b0,1'b0,8'h00, 64'd0,                 1'b0,5'd0,  64'd0,                 1'b1};
        vecs[18] = '{6'd62, 2'd0, 64'h0000_0000_0000_9004, 64'd0,                 5'd22, 5'd0,  0, 64'd0,                 1'b0,1'b0,8'h00, 64'd0,                 1'b0,5'd0,  64'd0,                 1'b1};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ready",   {63'd0, in_ready},  64'd1);
        chk("rst_req",     {63'd0, mem_req},   64'd0);
        chk("rst_we",      {63'd0, mem_we},    64'd0);
        chk("rst_addr",    {3'd0, mem_addr},   64'd0);
        chk("rst_be",      {56'd0, mem_be},    64'd0);
        chk("rst_wdata",   mem_wdata,          64'd0);
        chk("rst_valid",   {63'd0, out_valid}, 64'd0);
        chk("rst_wb",      {63'd0, out_wb_en}, 64'd0);
        chk("rst_exc",     {63'd0, out_exc},   64'd0);
        chk("rst_rd",      {59'd0, out_rd},    64'd0);
        chk("rst_data",    out_data,           64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Vector table
        for (int i = 0; i < 19; i++) run_vec(i, vecs[i]);

        // Stray ack while idle must not produce a completion
        mem_ack   = 1'b1;
        mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("stray_valid", {63'd0, out_valid}, 64'd0);
        chk("stray_ready", {63'd0, in_ready},  64'd1);
        chk("stray_req",   {63'd0, mem_req},   64'd0);

        // Back-to-back pass-through with in_valid held: accept every 2 cycles
        in_valid      = 1'b1;
        in_opcode     = 6'd14;
        in_alu_result = 64'h0000_0000_0000_0AAA;
        in_rd         = 5'd1;
        @(negedge clk);
        chk("b2b_valid1", {63'd0, out_valid}, 64'd1);
        chk("b2b_data1",  out_data, 64'h0000_0000_0000_0AAA);
        chk("b2b_busy",   {63'd0, in_ready}, 64'd0);
        in_alu_result = 64'h0000_0000_0000_0BBB;
        in_rd         = 5'd2;
        @(negedge clk);
        chk("b2b_gap",    {63'd0, out_valid}, 64'd0);
        chk("b2b_ready",  {63'd0, in_ready},  64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("b2b_valid2", {63'd0, out_valid}, 64'd1);
        chk("b2b_data2",  out_data, 64'h0000_0000_0000_0BBB);
        chk("b2b_rd2",    {59'd0, out_rd}, 64'd2);
        @(negedge clk);

        // Reset during BUS with a coincident ack drops the transaction
        in_valid      = 1'b1;
        in_opcode     = 6'd32;
        in_xods       = 2'd0;
        in_alu_result = 64'h0000_0000_0000_7000;
        in_rd         = 5'd12;
        @(negedge clk);
        in_valid = 1'b0;
        chk("rbus_req", {63'd0, mem_req}, 64'd1);
        rst       = 1'b1;
        mem_ack   = 1'b1;
        mem_rdata = 64'h8765_4321_0000_0000;
        @(negedge clk);
        rst     = 1'b0;
        mem_ack = 1'b0;
        chk("rbus_req_off", {63'd0, mem_req},   64'd0);
        chk("rbus_noval",   {63'd0, out_valid}, 64'd0);
        chk("rbus_ready",   {63'd0, in_ready},  64'd1);
        @(negedge clk);
        chk("rbus_noval2",  {63'd0, out_valid}, 64'd0);
        chk("rbus_req2",    {63'd0, mem_req},   64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
